// File: rtl/muldiv_seq.sv
// muldiv_seq: sequential M-extension multiply/divide unit sharing one radix-2 datapath.
// Optional MULDIV_EARLY_OUT_EN: divides with |a| < |b| skip the iteration loop.
module muldiv_seq #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [4:0]       op_i,
  input  logic [XLEN-1:0]  a_i,
  input  logic [XLEN-1:0]  b_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             busy_o
);
  localparam logic [4:0] OpMul    = 5'b01010;
  localparam logic [4:0] OpMulh   = 5'b01011;
  localparam logic [4:0] OpMulhu  = 5'b01100;
  localparam logic [4:0] OpMulhsu = 5'b01101;
  localparam logic [4:0] OpDivu   = 5'b01110;
  localparam logic [4:0] OpRemu   = 5'b01111;
  localparam logic [4:0] OpDiv    = 5'b10000;
  localparam logic [4:0] OpRem    = 5'b10001;
  localparam int unsigned CntW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MinVal = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StPrep, StBusy, StFix, StDone} state_e;
  state_e state_q, state_d;

  logic [4:0]       op_q, op_d;
  logic [XLEN-1:0]  a_q, a_d, b_q, b_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;   // |b|: multiplicand or divisor
  logic [2*XLEN:0]  acc_q, acc_d;   // mul: {0, hi, lo}; div: {rem[XLEN:0], quo}
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             a_neg_q, a_neg_d, b_neg_q, b_neg_d;
  logic [XLEN-1:0]  res_q, res_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic             is_mul, is_div, is_rem, sgn_a, sgn_b, a_neg, b_neg;
  logic [XLEN-1:0]  mag_a, mag_b, rem_fix, quo_s, rem_s;
  logic [XLEN:0]    mul_sum, rem_sh, rem_step;
  logic [2*XLEN-1:0] prod_s;

  always_comb begin
    is_mul = op_q inside {OpMul, OpMulh, OpMulhu, OpMulhsu};
    is_div = op_q inside {OpDivu, OpRemu, OpDiv, OpRem};
    is_rem = op_q inside {OpRemu, OpRem};
    sgn_a  = op_q inside {OpMul, OpMulh, OpMulhsu, OpDiv, OpRem};
    sgn_b  = op_q inside {OpMul, OpMulh, OpDiv, OpRem};
    a_neg  = sgn_a & a_q[XLEN-1];
    b_neg  = sgn_b & b_q[XLEN-1];
    mag_a  = a_neg ? -a_q : a_q;
    mag_b  = b_neg ? -b_q : b_q;

    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
    rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    rem_step = acc_q[2*XLEN] ? rem_sh + {1'b0, dvs_q} : rem_sh - {1'b0, dvs_q};

    // Final non-restoring correction; the corrected remainder fits in XLEN bits.
    rem_fix = acc_q[2*XLEN] ? acc_q[2*XLEN-1:XLEN] + dvs_q : acc_q[2*XLEN-1:XLEN];
    prod_s  = (a_neg_q ^ b_neg_q) ? -acc_q[2*XLEN-1:0] : acc_q[2*XLEN-1:0];
    quo_s   = (a_neg_q ^ b_neg_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_s   = a_neg_q ? -rem_fix : rem_fix;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    dvs_d   = dvs_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    a_neg_d = a_neg_q;
    b_neg_d = b_neg_q;
    res_d   = res_q;
    tag_d   = tag_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid_i && !flush_i) begin
          op_d    = op_i;
          a_d     = a_i;
          b_d     = b_i;
          tag_d   = tag_i;
          state_d = StPrep;
        end
      end
      StPrep: begin
        cnt_d   = CntW'(XLEN - 1);
        a_neg_d = a_neg;
        b_neg_d = b_neg;
        dvs_d   = mag_b;
        acc_d   = {{(XLEN+1){1'b0}}, mag_a};
        state_d = StDone;
        if (!is_mul && !is_div) begin
          res_d = '0;
        end else if (is_div && b_q == '0) begin
          res_d = is_rem ? a_q : '1;
        end else if (is_div && sgn_b && a_q == MinVal && b_q == '1) begin
          res_d = is_rem ? '0 : MinVal;
`ifdef MULDIV_EARLY_OUT_EN
        end else if (is_div && mag_a < mag_b) begin
          res_d = is_rem ? a_q : '0;
`endif
        end else begin
          state_d = StBusy;
        end
      end
      StBusy: begin
        acc_d = is_mul ? {1'b0, mul_sum, acc_q[XLEN-1:1]}
                       : {rem_step, acc_q[XLEN-2:0], ~rem_step[XLEN]};
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == '0) state_d = StFix;
      end
      StFix: begin
        case (op_q)
          OpMul:                     res_d = prod_s[XLEN-1:0];
          OpMulh, OpMulhu, OpMulhsu: res_d = prod_s[2*XLEN-1:XLEN];
          OpDiv, OpDivu:             res_d = quo_s;
          default:                   res_d = rem_s;
        endcase
        state_d = StDone;
      end
      StDone: begin
        if (out_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (flush_i) state_d = StIdle;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      dvs_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      res_q   <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dvs_q   <= dvs_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      a_neg_q <= a_neg_d;
      b_neg_q <= b_neg_d;
      res_q   <= res_d;
      tag_q   <= tag_d;
    end
  end

  assign in_ready_o  = (state_q == StIdle) && !flush_i;
  assign out_valid_o = (state_q == StDone);
  assign busy_o      = (state_q != StIdle);
  assign result_o    = res_q;
  assign tag_o       = tag_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed and randomized checks of muldiv_seq against a transaction-level model.
`timescale 1ns/1ps
module tb_muldiv_seq;
  localparam logic [4:0] OpMul    = 5'b01010;
  localparam logic [4:0] OpMulh   = 5'b01011;
  localparam logic [4:0] OpMulhu  = 5'b01100;
  localparam logic [4:0] OpMulhsu = 5'b01101;
  localparam logic [4:0] OpDivu   = 5'b01110;
  localparam logic [4:0] OpRemu   = 5'b01111;
  localparam logic [4:0] OpDiv    = 5'b10000;
  localparam logic [4:0] OpRem    = 5'b10001;
  localparam int FullLat = 35;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [4:0]  op_i = '0;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic [4:0]  tag_i = '0;
  logic        flush_i = 1'b0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] result_o;
  logic [4:0]  tag_o;
  logic        busy_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  muldiv_seq #(.XLEN(32), .TAG_W(5)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .op_i(op_i), .a_i(a_i), .b_i(b_i), .tag_i(tag_i), .flush_i(flush_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .result_o(result_o),
    .tag_o(tag_o), .busy_o(busy_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, ua, ub, q;
    logic [63:0] p;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    p  = '0;
    case (op)
      OpMul:    begin p = sa * sb; return p[31:0]; end
      OpMulh:   begin p = sa * sb; return p[63:32]; end
      OpMulhu:  begin p = ua * ub; return p[63:32]; end
      OpMulhsu: begin p = sa * ub; return p[63:32]; end
      OpDivu:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OpRemu:   return (b == 0) ? a : a % b;
      OpDiv: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = sa / sb; p = q; return p[31:0];
      end
      OpRem: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        q = sa % sb; p = q; return p[31:0];
      end
      default: return 32'h0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [4:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    bit dv, sg;
    longint ma, mb;
    dv = op inside {OpDivu, OpRemu, OpDiv, OpRem};
    sg = op inside {OpDiv, OpRem};
    ma = sg ? longint'(signed'(a)) : longint'({32'h0, a});
    mb = sg ? longint'(signed'(b)) : longint'({32'h0, b});
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
    if (!(op inside {[OpMul:OpRem]})) return 2;
    if (dv && b == 0) return 2;
    if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
`ifdef MULDIV_EARLY_OUT_EN
    if (dv && ma < mb) return 2;
`endif
    return FullLat;
  endfunction

  // Transaction model: one op in flight, m_age counts cycles since accept.
  logic        m_busy = 1'b0;
  int          m_age = 0;
  int          m_lat = 0;
  logic [31:0] m_res = '0;
  logic [4:0]  m_tag = '0;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_busy <= 1'b0;
      m_age  <= 0;
    end else if (flush_i) begin
      m_busy <= 1'b0;
    end else if (!m_busy) begin
      if (in_valid_i) begin
        m_busy <= 1'b1;
        m_age  <= 1;
        m_lat  <= ref_lat(op_i, a_i, b_i);
        m_res  <= ref_res(op_i, a_i, b_i);
        m_tag  <= tag_i;
      end
    end else if (m_age >= m_lat && out_ready_i) begin
      m_busy <= 1'b0;
    end else begin
      m_age <= m_age + 1;
    end
  end

  always @(negedge clk_i) begin
    if (rst_ni) begin
      chk("out_valid", {31'b0, out_valid_o}, {31'b0, m_busy && m_age >= m_lat});
      chk("in_ready", {31'b0, in_ready_o}, {31'b0, !m_busy && !flush_i});
      chk("busy", {31'b0, busy_o}, {31'b0, m_busy});
      if (m_busy && m_age >= m_lat) begin
        chk("result", result_o, m_res);
        chk("tag", {27'b0, tag_o}, {27'b0, m_tag});
      end
    end
  end

  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input int hold,
                        output logic [31:0] res, output int lat);
    @(negedge clk_i);
    op_i = op; a_i = a; b_i = b; tag_i = tag; in_valid_i = 1'b1;
    @(posedge clk_i);
    #1 in_valid_i = 1'b0;
    lat = 1;
    @(negedge clk_i);
    while (!out_valid_o && lat < 100) begin
      @(posedge clk_i);
      lat++;
      @(negedge clk_i);
    end
    res = result_o;
    if (!out_valid_o) begin
      chk("out_valid within bound", {31'b0, out_valid_o}, 32'd1);
      flush_i = 1'b1;
      @(posedge clk_i);
      #1 flush_i = 1'b0;
    end else begin
      repeat (hold) @(negedge clk_i);
      out_ready_i = 1'b1;
      @(posedge clk_i);
      #1 out_ready_i = 1'b0;
    end
  endtask

  logic [31:0] res;
  int          lat;
  int          seen;
  logic [4:0]  ops [10] = '{OpMul, OpMulh, OpMulhu, OpMulhsu, OpDivu, OpRemu, OpDiv, OpRem,
                            5'b00000, 5'b11111};

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      4:       return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #12;
    chk("reset out_valid", {31'b0, out_valid_o}, 32'd0);
    chk("reset result", result_o, 32'd0);
    chk("reset tag", {27'b0, tag_o}, 32'd0);
    chk("reset busy", {31'b0, busy_o}, 32'd0);
    rst_ni = 1'b1;

    run_op(OpDiv, 32'hFFFF_FFF9, 32'd2, 5'd3, 0, res, lat);
    chk("DIV -7/2", res, 32'hFFFF_FFFD);
    chk("DIV latency", lat, FullLat);
    run_op(OpRem, 32'hFFFF_FFF9, 32'd2, 5'd4, 0, res, lat);
    chk("REM -7%2", res, 32'hFFFF_FFFF);
    run_op(OpDivu, 32'h1234, 32'd0, 5'd5, 0, res, lat);
    chk("DIVU by zero", res, 32'hFFFF_FFFF);
    chk("DIVU by zero latency", lat, 2);
    run_op(OpRemu, 32'h1234, 32'd0, 5'd6, 0, res, lat);
    chk("REMU by zero", res, 32'h1234);
    run_op(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 0, res, lat);
    chk("DIV overflow", res, 32'h8000_0000);
    chk("DIV overflow latency", lat, 2);
    run_op(OpRem, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 0, res, lat);
    chk("REM overflow", res, 32'h0);
    run_op(OpMulh, 32'h8000_0000, 32'h8000_0000, 5'd9, 0, res, lat);
    chk("MULH min*min", res, 32'h4000_0000);
    run_op(OpMulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 0, res, lat);
    chk("MULHU ones^2", res, 32'hFFFF_FFFE);
    run_op(OpMulhsu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 0, res, lat);
    chk("MULHSU -1*ones", res, 32'hFFFF_FFFF);
    run_op(OpMul, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 0, res, lat);
    chk("MUL -1*-1", res, 32'h1);
    chk("MUL latency", lat, FullLat);
    run_op(5'b00001, 32'h55, 32'h66, 5'd13, 0, res, lat);
    chk("invalid op", res, 32'h0);
    chk("invalid op latency", lat, 2);
    run_op(OpDivu, 32'd5, 32'd7, 5'd14, 0, res, lat);
    chk("DIVU 5/7", res, 32'h0);
`ifdef MULDIV_EARLY_OUT_EN
    chk("DIVU 5/7 latency", lat, 2);
`else
    chk("DIVU 5/7 latency", lat, FullLat);
`endif
    run_op(OpRemu, 32'd5, 32'd7, 5'd15, 0, res, lat);
    chk("REMU 5%7", res, 32'd5);

    // Backpressure in DONE for 5 cycles.
    run_op(OpDivu, 32'd100, 32'd7, 5'd21, 5, res, lat);
    chk("DIVU 100/7 held", res, 32'd14);

    // Flush during the 10th BUSY cycle.
    @(negedge clk_i);
    op_i = OpDiv; a_i = 32'd1000; b_i = 32'd3; tag_i = 5'd22; in_valid_i = 1'b1;
    @(posedge clk_i);
    #1 in_valid_i = 1'b0;
    repeat (10) @(posedge clk_i);
    @(negedge clk_i);
    chk("busy before flush", {31'b0, busy_o}, 32'd1);
    flush_i = 1'b1;
    @(posedge clk_i);
    #1 flush_i = 1'b0;
    @(negedge clk_i);
    chk("in_ready after flush", {31'b0, in_ready_o}, 32'd1);
    seen = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (out_valid_o) seen++;
    end
    chk("no result after flush", seen, 0);
    run_op(OpMul, 32'd3, 32'd4, 5'd23, 0, res, lat);
    chk("MUL 3*4 after flush", res, 32'd12);

    // Asynchronous reset in the middle of BUSY.
    @(negedge clk_i);
    op_i = OpDivu; a_i = 32'd999; b_i = 32'd9; tag_i = 5'd24; in_valid_i = 1'b1;
    @(posedge clk_i);
    #1 in_valid_i = 1'b0;
    repeat (8) @(posedge clk_i);
    @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    chk("mid reset out_valid", {31'b0, out_valid_o}, 32'd0);
    chk("mid reset result", result_o, 32'd0);
    chk("mid reset tag", {27'b0, tag_o}, 32'd0);
    chk("mid reset busy", {31'b0, busy_o}, 32'd0);
    #1 rst_ni = 1'b1;
    run_op(OpDiv, 32'hFFFF_FFF9, 32'd2, 5'd25, 0, res, lat);
    chk("DIV after reset", res, 32'hFFFF_FFFD);

    for (int i = 0; i < 150; i++) begin
      run_op(ops[$urandom_range(0, 9)], rand_operand(), rand_operand(),
             5'($urandom_range(0, 31)), $urandom_range(0, 3), res, lat);
    end

    repeat (3) @(negedge clk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
